// File: rtl/multiphase_clock_generator_if.sv
// Control/status bundle for multiphase_clock_generator.
// master: the controller that requests bursts and watches the phase clocks.
// slave : the generator itself; drives phase_clk, busy, done and the sck strobes.
interface multiphase_clock_generator_if #(
  parameter int DIVIDER_WIDTH = 8,
  parameter int NUM_PHASES    = 2,
  parameter int BURST_WIDTH   = 16
);
  logic [DIVIDER_WIDTH-1:0] div_factor;  // counts per phase step
  logic [BURST_WIDTH-1:0]   burst_len;   // full periods per burst, 0 = continuous
  logic                     cpol;        // idle level of all phase outputs
  logic                     start;       // one-cycle burst request
  logic                     stop;        // graceful stop request
  logic [NUM_PHASES-1:0]    phase_clk;   // registered phase clocks
  logic                     busy;        // burst in progress
  logic                     done;        // one-cycle completion pulse
  logic                     sck_lead;    // phase_clk[0] turns active this cycle
  logic                     sck_trail;   // phase_clk[0] turns inactive this cycle

  modport master (
    output div_factor, burst_len, cpol, start, stop,
    input  phase_clk, busy, done, sck_lead, sck_trail
  );

  modport slave (
    input  div_factor, burst_len, cpol, start, stop,
    output phase_clk, busy, done, sck_lead, sck_trail
  );
endinterface

// File: rtl/multiphase_clock_generator.sv
// Purpose : burst generator of NUM_PHASES registered clocks spaced 180/NUM_PHASES degrees apart.
// Latency : phase_clk[0] goes active the cycle after start is accepted; all outputs are flops.
// Backpr. : none; start is ignored while busy, stop only shortens a burst at a period boundary.
// Ports   : clk_in, reset (async, active high); bus (slave modport) carries div_factor,
//           burst_len, cpol, start, stop in and phase_clk, busy, done, sck_lead, sck_trail out.
module multiphase_clock_generator #(
  parameter int DIVIDER_WIDTH = 8,
  parameter int NUM_PHASES    = 2,   // 1..8
  parameter int BURST_WIDTH   = 16
) (
  input  logic                        clk_in,
  input  logic                        reset,
  multiphase_clock_generator_if.slave bus
);

  // Largest period is 2*N*(2^W-1) counts; the counter only ever holds up to one less.
  localparam longint PMAX = 2 * NUM_PHASES * ((longint'(1) << DIVIDER_WIDTH) - 1);
  localparam int     CW   = $clog2(PMAX);
  // One spare bit so phase window edges (up to a full period) never wrap.
  localparam int     PW   = CW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAST = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            plast_q, plast_d;      // latched P-1
  logic [BURST_WIDTH-1:0]   pcnt_q, pcnt_d;
  logic [BURST_WIDTH-1:0]   burst_q, burst_d;
  logic [DIVIDER_WIDTH-1:0] div_q, div_d;          // latched Deff
  logic                     cpol_q, cpol_d;
  logic                     stop_pend_q, stop_pend_d;
  logic [NUM_PHASES-1:0]    phase_q, phase_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     lead_q, lead_d;
  logic                     trail_q, trail_d;

  logic                     wrap;
  logic                     active;
  logic [DIVIDER_WIDTH-1:0] deff;
  logic [PW-1:0]            cnt_ext, lo, hi;

  assign wrap = (cnt_q == plast_q);
  assign deff = (bus.div_factor == '0) ? DIVIDER_WIDTH'(1) : bus.div_factor;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    plast_d     = plast_q;
    pcnt_d      = pcnt_q;
    burst_d     = burst_q;
    div_d       = div_q;
    cpol_d      = cpol_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cpol_d = bus.cpol;
        if (bus.start) begin
          div_d       = deff;
          // Modular product is exact because P-1 always fits in CW bits.
          plast_d     = CW'(2 * NUM_PHASES) * CW'(deff) - CW'(1);
          burst_d     = bus.burst_len;
          cnt_d       = '0;
          pcnt_d      = '0;
          stop_pend_d = 1'b0;
          // A stop arriving with start makes the first period the last one.
          state_d     = (bus.burst_len == BURST_WIDTH'(1) || bus.stop) ? LAST : RUN;
        end
      end
      RUN: begin
        stop_pend_d = stop_pend_q | bus.stop;
        cnt_d       = wrap ? '0 : cnt_q + CW'(1);
        if (wrap) begin
          pcnt_d = pcnt_q + BURST_WIDTH'(1);
          if (stop_pend_q || bus.stop ||
              (burst_q != '0 && pcnt_d == burst_q - BURST_WIDTH'(1)))
            state_d = LAST;
        end
      end
      LAST: begin
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        if (wrap) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so every output pin is a flop.
  always_comb begin
    active  = (state_d != IDLE);
    busy_d  = active;
    cnt_ext = {1'b0, cnt_d};
    lead_d  = active && (cnt_d == '0);
    trail_d = active && (cnt_ext == PW'(NUM_PHASES) * PW'(div_d));
    phase_d = {NUM_PHASES{cpol_d}};
    lo      = '0;
    hi      = '0;
    if (active) begin
      for (int k = 0; k < NUM_PHASES; k++) begin
        lo         = PW'(k) * PW'(div_d);
        hi         = PW'(k + NUM_PHASES) * PW'(div_d);
        phase_d[k] = (cnt_ext >= lo && cnt_ext < hi) ? ~cpol_d : cpol_d;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      plast_q     <= '0;
      pcnt_q      <= '0;
      burst_q     <= '0;
      div_q       <= '0;
      cpol_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      phase_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      lead_q      <= 1'b0;
      trail_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      plast_q     <= plast_d;
      pcnt_q      <= pcnt_d;
      burst_q     <= burst_d;
      div_q       <= div_d;
      cpol_q      <= cpol_d;
      stop_pend_q <= stop_pend_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      lead_q      <= lead_d;
      trail_q     <= trail_d;
    end
  end

  assign bus.phase_clk = phase_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sck_lead  = lead_q;
  assign bus.sck_trail = trail_q;

endmodule

// File: tb/tb_multiphase_clock_generator.sv
// Bench for multiphase_clock_generator: one 2-phase and one 4-phase instance.
// Each accepted start pushes the per-cycle expected outputs of the whole burst.
module tb_multiphase_clock_generator;

  logic clk_in = 1'b0;
  logic reset;
  always #5 clk_in = ~clk_in;

  multiphase_clock_generator_if #(.DIVIDER_WIDTH(8), .NUM_PHASES(2), .BURST_WIDTH(16)) bus2 ();
  multiphase_clock_generator_if #(.DIVIDER_WIDTH(8), .NUM_PHASES(4), .BURST_WIDTH(16)) bus4 ();

  multiphase_clock_generator #(.DIVIDER_WIDTH(8), .NUM_PHASES(2), .BURST_WIDTH(16)) dut2 (
    .clk_in(clk_in), .reset(reset), .bus(bus2)
  );
  multiphase_clock_generator #(.DIVIDER_WIDTH(8), .NUM_PHASES(4), .BURST_WIDTH(16)) dut4 (
    .clk_in(clk_in), .reset(reset), .bus(bus4)
  );

  // Expected per-cycle vector: {phase_clk padded to 8, busy, done, sck_lead, sck_trail}
  typedef struct {
    int          cyc;
    logic [11:0] vec;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  exp_t e2, e4;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   c0;

  logic [11:0] obs2_vec, obs4_vec;
  assign obs2_vec = {6'b0, bus2.phase_clk, bus2.busy, bus2.done, bus2.sck_lead, bus2.sck_trail};
  assign obs4_vec = {4'b0, bus4.phase_clk, bus4.busy, bus4.done, bus4.sck_lead, bus4.sck_trail};

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h, want %h", tag, cyc, obs, req);
    end
  endtask

  task automatic push_exp(input bit four, input int c, input logic [11:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    if (four) q4.push_back(e);
    else      q2.push_back(e);
  endtask

  // Reference trace: nper full periods, then the done cycle and two idle cycles.
  task automatic push_burst(input bit four, input int c_first, input int n, input int d,
                            input int nper, input logic pol);
    int         p;
    int         cy;
    logic [7:0] ph;
    p  = 2 * n * d;
    cy = c_first;
    for (int b = 0; b < nper; b++) begin
      for (int c = 0; c < p; c++) begin
        ph = '0;
        for (int k = 0; k < n; k++)
          ph[k] = ((k * d <= c) && (c < (k + n) * d)) ? ~pol : pol;
        push_exp(four, cy, {ph, 1'b1, 1'b0, (c == 0), (c == n * d)});
        cy++;
      end
    end
    ph = '0;
    for (int k = 0; k < n; k++) ph[k] = pol;
    push_exp(four, cy,     {ph, 4'b0100});
    push_exp(four, cy + 1, {ph, 4'b0000});
    push_exp(four, cy + 2, {ph, 4'b0000});
  endtask

  always @(negedge clk_in) begin
    while (q2.size() > 0 && q2[0].cyc <= cyc) begin
      e2 = q2.pop_front();
      check_eq("n2_trace", 32'(obs2_vec), 32'(e2.vec));
    end
    while (q4.size() > 0 && q4[0].cyc <= cyc) begin
      e4 = q4.pop_front();
      check_eq("n4_trace", 32'(obs4_vec), 32'(e4.vec));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic fire(input bit four, input int n, input int d, input int nper,
                      input logic pol, input bit with_stop, output int cs);
    cs = cyc;
    push_burst(four, cs + 1, n, d, nper, pol);
    if (four) begin
      bus4.start = 1'b1;
      bus4.stop  = with_stop;
    end else begin
      bus2.start = 1'b1;
      bus2.stop  = with_stop;
    end
    step(1);
    bus2.start = 1'b0; bus2.stop = 1'b0;
    bus4.start = 1'b0; bus4.stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus2.div_factor = '0; bus2.burst_len = '0; bus2.cpol = 1'b0; bus2.start = 1'b0; bus2.stop = 1'b0;
    bus4.div_factor = '0; bus4.burst_len = '0; bus4.cpol = 1'b0; bus4.start = 1'b0; bus4.stop = 1'b0;
    step(2);
    check_eq("rst_n2", 32'(obs2_vec), 32'h0);
    check_eq("rst_n4", 32'(obs4_vec), 32'h0);
    reset = 1'b0;
    step(2);
    check_eq("idle_n2", 32'(obs2_vec), 32'h0);

    // N=2, D=3, two periods, cpol=0
    bus2.div_factor = 8'd3; bus2.burst_len = 16'd2; bus2.cpol = 1'b0;
    fire(1'b0, 2, 3, 2, 1'b0, 1'b0, c0);
    wait_until(c0 + 24 + 4);

    // N=4, D=1, single period, cpol=1; idle level follows live cpol first
    bus4.div_factor = 8'd1; bus4.burst_len = 16'd1; bus4.cpol = 1'b1;
    step(2);
    check_eq("idle_cpol_n4", 32'(bus4.phase_clk), 32'hF);
    fire(1'b1, 4, 1, 1, 1'b1, 1'b0, c0);
    wait_until(c0 + 8 + 4);

    // div_factor=0 -> D=1, continuous; stop at count 1 of the third period
    bus2.div_factor = 8'd0; bus2.burst_len = 16'd0;
    fire(1'b0, 2, 1, 4, 1'b0, 1'b0, c0);
    wait_until(c0 + 10);
    bus2.stop = 1'b1;
    step(1);
    bus2.stop = 1'b0;
    wait_until(c0 + 16 + 4);

    // start re-pulsed while busy with new settings must be ignored
    bus2.div_factor = 8'd3; bus2.burst_len = 16'd2;
    fire(1'b0, 2, 3, 2, 1'b0, 1'b0, c0);
    wait_until(c0 + 5);
    bus2.div_factor = 8'd5; bus2.burst_len = 16'd7; bus2.start = 1'b1;
    step(1);
    bus2.start = 1'b0;
    wait_until(c0 + 24 + 4);

    // start and stop together, continuous mode -> one period
    bus2.div_factor = 8'd2; bus2.burst_len = 16'd0;
    fire(1'b0, 2, 2, 1, 1'b0, 1'b1, c0);
    wait_until(c0 + 8 + 4);

    // asynchronous reset mid-period, then a fresh two-period burst
    bus2.div_factor = 8'd3; bus2.burst_len = 16'd2;
    fire(1'b0, 2, 3, 2, 1'b0, 1'b0, c0);
    wait_until(c0 + 7);
    check_eq("pre_arst_busy", 32'(bus2.busy), 32'h1);
    #2;
    reset = 1'b1;
    q2.delete();
    #1;
    check_eq("arst_n2", 32'(obs2_vec), 32'h0);
    step(2);
    check_eq("arst_hold_n2", 32'(obs2_vec), 32'h0);
    bus2.cpol = 1'b1;
    reset = 1'b0;
    step(1);
    check_eq("rel_cpol", 32'(bus2.phase_clk), 32'h3);
    check_eq("rel_nodone", 32'(bus2.done), 32'h0);
    bus2.cpol = 1'b0;
    step(2);
    fire(1'b0, 2, 3, 2, 1'b0, 1'b0, c0);
    wait_until(c0 + 24 + 4);

    check_eq("q2_drain", 32'(q2.size()), 32'h0);
    check_eq("q4_drain", 32'(q4.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
